// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: FSM state type and counter sizing shared by the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {ASSERT_ALL, WAIT_LOCK, RELEASE, RUN} state_e;

   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset to RESET_VAL.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all domains in reset until PLL lock is stable, then releases
// them in order one stage per interval, and records the cause of the last reset.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int                     NUM_SOURCES   = 4,
   parameter int                     NUM_STAGES    = 3,
   parameter int                     STAGE_DELAY   = 1024,
   parameter int                     STABLE_CYCLES = 256,
   parameter logic [NUM_SOURCES-1:0] PLL_RST_MASK  = '1
) (
   input  logic                   independent_clk,
   input  logic                   rst,
   input  logic                   pll_lock,
   input  logic [NUM_SOURCES-1:0] rst_req,
   output logic                   pll_rst_req,
   output logic [NUM_STAGES-1:0]  stage_rst,
   output logic                   ready,
   output logic [NUM_SOURCES:0]   last_cause
);

   localparam int CW = cnt_width(STAGE_DELAY, STABLE_CYCLES);
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CW-1:0] DELAY_END  = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] STABLE_END = CW'(STABLE_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_STAGES - 1);

   if (STAGE_DELAY < 2) begin : g_bad_delay
      $error("reset_sequencer: STAGE_DELAY must be at least 2");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("reset_sequencer: STABLE_CYCLES must be at least 1");
   end
   if (NUM_STAGES < 1) begin : g_bad_stages
      $error("reset_sequencer: NUM_STAGES must be at least 1");
   end

   logic [NUM_SOURCES-1:0] req_s;
   logic                   lock_s;
   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
   logic                   ready_q, ready_d;
   logic                   pll_rst_req_q, pll_rst_req_d;
   logic [NUM_SOURCES:0]   last_cause_q, last_cause_d;
   logic                   pll_flag_q, pll_flag_d;
   logic                   req_any, lock_lost, abort;

   sync_2ff #(.WIDTH(NUM_SOURCES), .RESET_VAL('0)) u_req_sync (
      .clk(independent_clk), .rst(rst), .d(rst_req), .q(req_s)
   );

   sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_lock_sync (
      .clk(independent_clk), .rst(rst), .d(pll_lock), .q(lock_s)
   );

   // Lock is only a fault once release has started; WAIT_LOCK just restarts its count.
   always_comb begin
      req_any      = |req_s;
      lock_lost    = !lock_s && (state_q == RELEASE || state_q == RUN);
      abort        = state_q != ASSERT_ALL && (req_any || lock_lost);
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      stage_rst_d  = stage_rst_q;
      last_cause_d = last_cause_q;
      pll_flag_d   = pll_flag_q;
      if (abort) begin
         state_d      = ASSERT_ALL;
         cnt_d        = '0;
         stage_rst_d  = '1;
         last_cause_d = {lock_lost, req_s};
         pll_flag_d   = |(req_s & PLL_RST_MASK);
      end else begin
         case (state_q)
            ASSERT_ALL: begin
               stage_rst_d  = '1;
               last_cause_d = last_cause_q | {1'b0, req_s};
               pll_flag_d   = pll_flag_q || (|(req_s & PLL_RST_MASK));
               cnt_d        = req_any ? '0 : cnt_q + 1'b1;
               if (!req_any && cnt_q == DELAY_END) begin
                  state_d    = WAIT_LOCK;
                  cnt_d      = '0;
                  pll_flag_d = 1'b0;
               end
            end
            WAIT_LOCK: begin
               cnt_d = lock_s ? cnt_q + 1'b1 : '0;
               if (lock_s && cnt_q == STABLE_END) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end
            end
            RELEASE: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == DELAY_END) begin
                  cnt_d              = '0;
                  stage_rst_d[idx_q] = 1'b0;
                  idx_d              = idx_q + 1'b1;
                  state_d            = (idx_q == LAST_IDX) ? RUN : RELEASE;
               end
            end
            RUN: stage_rst_d = '0;
         endcase
      end
      ready_d       = state_d == RUN;
      pll_rst_req_d = state_d == ASSERT_ALL && pll_flag_d;
   end

   always_ff @(posedge independent_clk or posedge rst) begin
      if (rst) begin
         state_q       <= ASSERT_ALL;
         cnt_q         <= '0;
         idx_q         <= '0;
         stage_rst_q   <= '1;
         ready_q       <= 1'b0;
         pll_rst_req_q <= 1'b0;
         last_cause_q  <= '0;
         pll_flag_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         stage_rst_q   <= stage_rst_d;
         ready_q       <= ready_d;
         pll_rst_req_q <= pll_rst_req_d;
         last_cause_q  <= last_cause_d;
         pll_flag_q    <= pll_flag_d;
      end
   end

   assign stage_rst   = stage_rst_q;
   assign ready       = ready_q;
   assign pll_rst_req = pll_rst_req_q;
   assign last_cause  = last_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized disturbances in each phase; expected output changes
// (edge number and value) are queued by the stimulus and checked by a separate monitor.
module tb_reset_sequencer;

   localparam logic [7:0] RST_V = 8'b111_0_0_000;

   typedef struct {
      int         t;
      logic [7:0] v;
   } ev_t;

   logic       independent_clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b1;
   logic [1:0] rst_req = 2'b00;
   logic       pll_rst_req;
   logic [2:0] stage_rst;
   logic       ready;
   logic [2:0] last_cause;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   ev_t        exp_q[$];
   logic [7:0] exp_cur = RST_V;
   logic [2:0] m_cause = 3'b000;
   int         tx, tx2, k, m, n, r;
   logic [1:0] mask;

   reset_sequencer #(
      .NUM_SOURCES(2), .NUM_STAGES(3), .STAGE_DELAY(8), .STABLE_CYCLES(4), .PLL_RST_MASK(2'b01)
   ) dut (
      .independent_clk(independent_clk),
      .rst(rst),
      .pll_lock(pll_lock),
      .rst_req(rst_req),
      .pll_rst_req(pll_rst_req),
      .stage_rst(stage_rst),
      .ready(ready),
      .last_cause(last_cause)
   );

   always #5 independent_clk = ~independent_clk;

   always @(posedge independent_clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_stage_rst"}, 8'(stage_rst), 8'h07);
      check({tag, "_ready"}, 8'(ready), 8'h00);
      check({tag, "_pll_rst_req"}, 8'(pll_rst_req), 8'h00);
      check({tag, "_last_cause"}, 8'(last_cause), 8'h00);
   endtask

   task automatic run_monitor();
      logic [7:0] prev, cur;
      ev_t        e;
      prev = RST_V;
      forever begin
         @(negedge independent_clk);
         cur = {stage_rst, ready, pll_rst_req, last_cause};
         if (cur !== prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: got %b at edge %0d, required no change from %b", cur, cyc, prev);
            end else begin
               e = exp_q.pop_front();
               if (e.t != cyc || e.v !== cur) begin
                  n_fail++;
                  $display("FAIL output_event: got %b at edge %0d, required %b at edge %0d", cur, cyc, e.v, e.t);
               end
            end
            prev = cur;
         end
      end
   endtask

   // Queue an output change only when the expected output tuple actually changes.
   task automatic expect_at(input int t, input logic [2:0] st, input logic rdy, input logic pll, input logic [2:0] cause);
      logic [7:0] v;
      v = {st, rdy, pll, cause};
      if (v !== exp_cur) begin
         exp_q.push_back('{t, v});
         exp_cur = v;
      end
   endtask

   task automatic push_stages(input int t0);
      expect_at(t0, 3'b110, 1'b0, 1'b0, m_cause);
      expect_at(t0 + 8, 3'b100, 1'b0, 1'b0, m_cause);
      expect_at(t0 + 16, 3'b000, 1'b1, 1'b0, m_cause);
   endtask

   task automatic push_release(input int tx_in);
      expect_at(tx_in, 3'b111, 1'b0, 1'b0, m_cause);
      push_stages(tx_in + 12);
   endtask

   task automatic wait_edge(input int t);
      while (cyc < t) @(negedge independent_clk);
   endtask

   task automatic drained(input string name);
      check({"drained_", name}, 8'(exp_q.size()), 8'd0);
   endtask

   // Request pulse of len cycles and/or lock drop of lp cycles starting now (called at a
   // negedge while lock-loss would abort). Returns the edge where ASSERT_ALL ends.
   task automatic disturb(input logic [1:0] msk, input int len, input int lp, output int tx_out);
      int kk, span;
      kk      = cyc;
      m_cause = {lp > 0 ? 1'b1 : 1'b0, msk};
      expect_at(kk + 3, 3'b111, 1'b0, msk[0], m_cause);
      tx_out = (msk != 2'b00) ? kk + len + 10 : kk + 11;
      expect_at(tx_out, 3'b111, 1'b0, 1'b0, m_cause);
      span = (len > lp) ? len : lp;
      for (int i = 0; i < span; i++) begin
         rst_req  = (i < len) ? msk : 2'b00;
         pll_lock = (i >= lp);
         @(negedge independent_clk);
      end
      rst_req  = 2'b00;
      pll_lock = 1'b1;
   endtask

   initial begin
      fork
         run_monitor();
      join_none
      repeat (3) @(negedge independent_clk);
      check_reset("reset");
      rst = 1'b0;
      k = cyc;
      push_release(k + 8);
      wait_edge(k + 8 + 30);
      drained("powerup");

      disturb(2'b01, int'($urandom_range(1, 4)), 0, tx);
      push_release(tx);
      wait_edge(tx + 30);
      drained("req0_pulse");

      disturb(2'b10, int'($urandom_range(1, 5)), 0, tx);
      n = int'($urandom_range(6, 9));
      for (int p = 0; p < n; p++) begin
         pll_lock = 1'b0;
         m = cyc;
         @(negedge independent_clk);
         pll_lock = 1'b1;
         repeat (2) @(negedge independent_clk);
      end
      check("bounce_stage_rst", 8'(stage_rst), 8'h07);
      check("bounce_ready", 8'(ready), 8'h00);
      push_stages(m + 15);
      wait_edge(m + 33);
      drained("lock_bounce");

      disturb(2'b10, 1, 0, tx);
      expect_at(tx + 12, 3'b110, 1'b0, 1'b0, m_cause);
      wait_edge(tx + 12 + int'($urandom_range(0, 4)));
      disturb(2'b10, 20, 0, tx2);
      push_release(tx2);
      wait_edge(tx2 + 30);
      drained("req1_in_release");

      disturb(2'b01, int'($urandom_range(1, 6)), 3, tx);
      check("lock_and_req_cause", 8'(last_cause), 8'h05);
      push_release(tx);
      wait_edge(tx + 30);
      drained("lock_and_req");

      for (int it = 0; it < 4; it++) begin
         r = int'($urandom_range(0, 2));
         mask = 2'($urandom_range(1, 3));
         if (r == 0) disturb(mask, int'($urandom_range(1, 6)), 0, tx);
         else if (r == 1) disturb(2'b00, 0, int'($urandom_range(1, 4)), tx);
         else disturb(mask, int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), tx);
         push_release(tx);
         wait_edge(tx + 30);
         drained("random_abort");
      end

      disturb(2'b01, int'($urandom_range(1, 4)), 0, tx);
      expect_at(tx + 12, 3'b110, 1'b0, 1'b0, m_cause);
      wait_edge(tx + 12 + int'($urandom_range(0, 6)));
      k = cyc;
      m_cause = 3'b000;
      expect_at(k + 1, 3'b111, 1'b0, 1'b0, 3'b000);
      #1 rst = 1'b1;
      #1 check_reset("mid_release_rst");
      repeat (2) @(negedge independent_clk);
      rst = 1'b0;
      k = cyc;
      push_release(k + 8);
      wait_edge(k + 8 + 30);
      drained("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
